// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// buffers {pc, word} pairs in a 2-entry FIFO towards decode over valid/ready.
// A redirect reloads the PC with the word-aligned target and flushes the buffer.
module fetch_stage #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   output logic [ADDRESS_WIDTH-1:0] o_imem_addr,
   input  logic [31:0]              i_imem_instr,
   input  logic                     i_redirect_en,
   input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
   output logic                     o_instr_valid,
   input  logic                     i_instr_ready,
   output logic [31:0]              o_instr,
   output logic [ADDRESS_WIDTH-1:0] o_instr_pc,
   output logic [1:0]               o_buf_count
);

   typedef logic [ADDRESS_WIDTH-1:0] addr_t;

   addr_t       r_pc;
   addr_t       r_buf_pc   [2];
   logic [31:0] r_buf_word [2];
   logic [1:0]  r_count;
   logic        r_rd_ptr;

   addr_t       w_pc_d;
   logic [1:0]  w_count_d;
   logic        w_rd_ptr_d;
   logic        w_valid;
   logic        w_pop;
   logic        w_push;
   logic        w_wr_idx;
   addr_t       w_redirect_aligned;

   assign w_valid            = (r_count != 2'd0);
   assign w_pop              = w_valid & i_instr_ready;
   assign w_push             = ~i_redirect_en & ((r_count < 2'd2) | w_pop);
   // Tail slot: one past the head when one entry is held; the head slot itself when
   // empty or when full (full implies a pop is freeing that slot this cycle).
   assign w_wr_idx           = r_rd_ptr ^ r_count[0];
   assign w_redirect_aligned = i_redirect_pc & ~addr_t'(3);

   assign o_imem_addr   = r_pc;
   assign o_instr_valid = w_valid;
   assign o_instr       = r_buf_word[r_rd_ptr];
   assign o_instr_pc    = r_buf_pc[r_rd_ptr];
   assign o_buf_count   = r_count;

   // Next-state for PC, occupancy and read pointer; redirect overrides push and pop.
   always_comb begin
      w_pc_d     = r_pc;
      w_count_d  = r_count;
      w_rd_ptr_d = r_rd_ptr;
      if (i_redirect_en) begin
         w_pc_d     = w_redirect_aligned;
         w_count_d  = 2'd0;
         w_rd_ptr_d = 1'b0;
      end else begin
         if (w_push) begin
            w_pc_d = r_pc + addr_t'(4);
         end
         if (w_pop) begin
            w_rd_ptr_d = ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + 2'd1;
            2'b01:   w_count_d = r_count - 2'd1;
            default: w_count_d = r_count;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc     <= RESET_PC;
         r_count  <= 2'd0;
         r_rd_ptr <= 1'b0;
      end else begin
         r_pc     <= w_pc_d;
         r_count  <= w_count_d;
         r_rd_ptr <= w_rd_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so head outputs are never X.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_buf_pc[0]   <= '0;
         r_buf_pc[1]   <= '0;
         r_buf_word[0] <= '0;
         r_buf_word[1] <= '0;
      end else if (w_push) begin
         r_buf_pc[w_wr_idx]   <= r_pc;
         r_buf_word[w_wr_idx] <= i_imem_instr;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage. Memory returns its own address as data.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [1:0]  buf_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_instr = imem_addr;

   fetch_stage #(
      .ADDRESS_WIDTH(32),
      .RESET_PC     (32'h0)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .o_imem_addr  (imem_addr),
      .i_imem_instr (imem_instr),
      .i_redirect_en(redirect_en),
      .i_redirect_pc(redirect_pc),
      .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready),
      .o_instr      (instr),
      .o_instr_pc   (instr_pc),
      .o_buf_count  (buf_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [1:0] cnt);
      check_eq({tag, ".valid"}, 64'(instr_valid), 64'd1);
      check_eq({tag, ".pc"}, 64'(instr_pc), 64'(pc));
      check_eq({tag, ".instr"}, 64'(instr), 64'(pc));
      check_eq({tag, ".count"}, 64'(buf_count), 64'(cnt));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, ".valid"}, 64'(instr_valid), 64'd0);
      check_eq({tag, ".count"}, 64'(buf_count), 64'd0);
      check_eq({tag, ".addr"}, 64'(imem_addr), 64'd0);
      check_eq({tag, ".instr"}, 64'(instr), 64'd0);
      check_eq({tag, ".pc"}, 64'(instr_pc), 64'd0);
   endtask

   logic [31:0] exp_pc;
   logic        prev_stall;
   logic [31:0] prev_pc;
   logic [31:0] prev_instr;
   logic        rnd_ready;
   logic        rnd_redir;
   logic [31:0] rnd_target;

   initial begin
      rst         = 1'b1;
      redirect_en = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b1;

      // Reset held for two cycles, then streaming with ready high.
      tick();
      tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      tick();
      check_head("stream0", 32'h0, 2'd1);
      check_eq("stream0.addr", 64'(imem_addr), 64'h4);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_head("stream", 32'(i * 4), 2'd1);
      end

      // Backpressure from release.
      rst = 1'b1;
      instr_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check_head("bp1", 32'h0, 2'd1);
      tick();
      check_head("bp2", 32'h0, 2'd2);
      check_eq("bp2.addr", 64'(imem_addr), 64'h8);
      tick();
      check_head("bp3", 32'h0, 2'd2);
      check_eq("bp3.addr", 64'(imem_addr), 64'h8);
      instr_ready = 1'b1;
      tick();
      check_head("bp_rel1", 32'h4, 2'd2);
      tick();
      check_head("bp_rel2", 32'h8, 2'd2);

      // Redirect while full; low target bits must be dropped.
      redirect_en = 1'b1;
      redirect_pc = 32'h103;
      tick();
      redirect_en = 1'b0;
      check_eq("redir.valid", 64'(instr_valid), 64'd0);
      check_eq("redir.count", 64'(buf_count), 64'd0);
      check_eq("redir.addr", 64'(imem_addr), 64'h100);
      tick();
      check_head("redir_tgt", 32'h100, 2'd1);

      // Wrap-around at the top of the address space.
      redirect_en = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_en = 1'b0;
      tick();
      check_head("wrap0", 32'hFFFF_FFF8, 2'd1);
      tick();
      check_head("wrap1", 32'hFFFF_FFFC, 2'd1);
      tick();
      check_head("wrap2", 32'h0, 2'd1);

      // Back-to-back redirects: last one wins.
      redirect_en = 1'b1;
      redirect_pc = 32'h500;
      tick();
      redirect_pc = 32'h600;
      tick();
      redirect_en = 1'b0;
      check_eq("b2b.valid", 64'(instr_valid), 64'd0);
      check_eq("b2b.addr", 64'(imem_addr), 64'h600);
      tick();
      check_head("b2b_tgt", 32'h600, 2'd1);

      // Reset while full of high-address entries.
      redirect_en = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_en = 1'b0;
      instr_ready = 1'b0;
      tick();
      tick();
      check_head("mid_full", 32'h200, 2'd2);
      rst = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h700;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      redirect_en = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_head("post_rst", 32'(i * 4), 2'd1);
      end

      // Random ready and redirects, checked against a PC scoreboard.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_pc     = 32'h0;
      prev_stall = 1'b0;
      prev_pc    = '0;
      prev_instr = '0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (prev_stall) begin
            check_eq("stall.valid", 64'(instr_valid), 64'd1);
            check_eq("stall.pc", 64'(instr_pc), 64'(prev_pc));
            check_eq("stall.instr", 64'(instr), 64'(prev_instr));
         end
         rnd_ready  = ($urandom_range(0, 2) != 0);
         rnd_redir  = ($urandom_range(0, 19) == 0);
         rnd_target = $urandom;
         instr_ready = rnd_ready;
         redirect_en = rnd_redir;
         redirect_pc = rnd_target;
         if (instr_valid && rnd_ready && !rnd_redir) begin
            check_eq("sb.pc", 64'(instr_pc), 64'(exp_pc));
            check_eq("sb.instr", 64'(instr), 64'(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         if (rnd_redir) begin
            exp_pc = rnd_target & ~32'd3;
         end
         prev_stall = instr_valid && !rnd_ready && !rnd_redir;
         prev_pc    = instr_pc;
         prev_instr = instr;
      end
      redirect_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the instruction memory and downstream-facing to decode. Holds the program counter and drives the memory address. Captures the returned word together with its PC into a 2-entry buffer. Presents entries to decode over a valid/ready handshake and supports single-cycle redirect (branch/jump) with flush.

## Interface
- ADDRESS_WIDTH, 32, width of PC and memory address
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDRESS_WIDTH  byte address to instruction memory; equals current PC
- imem_instr  in  32  instruction word for imem_addr, combinational same-cycle read
- redirect_en  in  1  load new PC and flush buffer this cycle
- redirect_pc  in  ADDRESS_WIDTH  redirect target
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decode accepts head this cycle
- instr  out  32  head instruction word
- instr_pc  out  ADDRESS_WIDTH  PC of head instruction
- buf_count  out  2  buffer occupancy, 0..2

## Operation
- State: pc register; 2-entry FIFO of {pc, word}; 2-bit count; 1-bit read pointer.
- imem_addr = pc (combinational from register).
- pop = instr_valid && instr_ready.
- fetch_en = !redirect_en && (count < 2 || pop).
- On fetch_en: push {pc, imem_instr}; pc <= pc + 4, modulo 2^ADDRESS_WIDTH (0xFFFFFFFC wraps to 0x0).
- count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- instr_valid = (count != 0); instr/instr_pc = FIFO head; when count==0, values are don't-care but must not be X after reset.
- Redirect (highest priority, overrides push and pop):
  - pc <= {redirect_pc[AW-1:2], 2'b00} (low bits forced to zero).
  - count <= 0.
  - Any handshake in that cycle is discarded, and decode flushes too.
  - No push that cycle.
- Full with no pop: pc holds, imem_addr stable, no push.
- Reset: pc = RESET_PC, count = 0, pointers = 0, FIFO storage = 0.
  - Outputs during and after reset: instr_valid=0, buf_count=0, imem_addr=RESET_PC, instr=0, instr_pc=0.
  - Reset overrides redirect and handshake.
- Reset mid-operation discards all buffered entries; no entry issued before reset appears afterwards.

## Timing
- Fetch-to-valid latency: 1 cycle. A word fetched in cycle N is at the head, valid, in cycle N+1 if the buffer was empty.
- First edge with rst=0: fetches RESET_PC. instr_valid rises the following cycle.
- Steady-state throughput with instr_ready held high: 1 instruction per cycle, buf_count stays 1.
- Ready low: buffer fills in 2 cycles, then the fetch stalls. When ready returns, the pop and a refill fetch occur in the same cycle (no bubble).
- Redirect asserted in cycle N:
  - Cycle N+1: imem_addr = target, instr_valid = 0.
  - Cycle N+2: target instruction valid.
  - Redirect penalty: 1 bubble cycle.
- Back-to-back redirects: the last one wins. No entries are pushed during redirect cycles.
- Handshake rules:
  - instr, instr_pc and instr_valid are stable while instr_valid=1 and instr_ready=0, unless redirect or reset occurs.
  - instr_valid does not depend combinationally on instr_ready.

## Test plan
- Memory word at address A = A, RESET_PC=0. Hold rst for 2 cycles, then release with instr_ready=1.
  - Required: cycle 1 after release gives instr_pc=0x0 and instr=0x0.
  - Then instr_pc=0x4, 0x8, 0xC on consecutive cycles, buf_count=1 throughout.
- Backpressure: instr_ready=0 from the start.
  - Required: buf_count goes 1, 2, 2. imem_addr holds 0x8. Head stays at pc 0x0.
  - Raise ready: pcs 0x0, 0x4, 0x8 are delivered in order, with no gap and no duplicate.
- Redirect with buffer full: redirect_en=1, redirect_pc=0x103 while instr_ready=1.
  - Required next cycle: buf_count=0, instr_valid=0, imem_addr=0x100.
  - Following cycle: instr_pc=0x100.
- Wrap-around: redirect_pc=0xFFFFFFF8.
  - Required: instr_pc sequence is 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- Reset mid-stream: with buf_count=2, assert rst for 1 cycle.
  - Required next cycle: instr_valid=0, buf_count=0, imem_addr=RESET_PC.
  - No pre-reset PC ever appears afterwards.
- Random instr_ready toggling over 1000 cycles with random redirects.
  - Required: the scoreboard sees instr_pc increment by 4 between accepted entries, except right after a redirect, where it equals the aligned target.
  - Valid/data are stable under stall.
